// File: rtl/debouncer_2ch.sv
// Two-channel synchroniser plus debouncer feeding the 2-bit edge detector.
// Optional macro DEBOUNCE_SYNC3_EN deepens each synchroniser to three flops.
module debouncer_2ch #(
   parameter int N_ESTAVEL = 4,
   parameter int CNT_W     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] bruto,
   output logic [1:0] saida,
   output logic       ocupado
);

`ifdef DEBOUNCE_SYNC3_EN
   localparam int SYNC_D = 3;
`else
   localparam int SYNC_D = 2;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ESTAVEL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_D-1:0] sync_q [2];
   logic [CNT_W-1:0]  cnt    [2];
   logic [1:0]        s;

   always_comb begin
      s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         s[i] = sync_q[i][SYNC_D-1];
      end
   end

   // Shared rule on both channels keeps simultaneous changes aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         saida <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_D-2:0], bruto[i]};
            if (s[i] == saida[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               saida[i] <= s[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign ocupado = (cnt[0] != '0) | (cnt[1] != '0);

endmodule

// File: tb/tb_debouncer_2ch.sv
// Self-checking bench for debouncer_2ch: vector table, corner sequences
// and randomised stimulus against a sample-window reference model.
module tb_debouncer_2ch;

   localparam int N     = 4;
   localparam int CNT_W = 3;
`ifdef DEBOUNCE_SYNC3_EN
   localparam int D = 3;
`else
   localparam int D = 2;
`endif
   localparam int LAT = N + D - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] bruto = 2'b00;
   logic [1:0] saida;
   logic       ocupado;

   int n_vec = 0;
   int n_bad = 0;

   debouncer_2ch #(.N_ESTAVEL(N), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bruto   (bruto),
      .saida   (saida),
      .ocupado (ocupado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [1:0] b;
      logic [1:0] exp_s;
      logic       exp_o;
   } vec_t;

   vec_t tbl[$];

   // Model: synchroniser as a delay line, output flips when the last N
   // synchronised samples all disagree with it.
   logic [1:0] pipe [D];
   bit         win  [2][N];
   logic [1:0] m_saida = 2'b00;
   logic       m_ocup = 1'b0;

   task automatic model_edge(input logic r, input logic [1:0] b);
      if (r) begin
         for (int j = 0; j < D; j++) pipe[j] = 2'b00;
         for (int c = 0; c < 2; c++)
            for (int j = 0; j < N; j++) win[c][j] = 1'b0;
         m_saida = 2'b00;
      end else begin
         for (int c = 0; c < 2; c++) begin
            bit smp;
            bit all_diff;
            smp = pipe[D-1][c];
            for (int j = N - 1; j > 0; j--) win[c][j] = win[c][j-1];
            win[c][0] = smp;
            all_diff = 1'b1;
            for (int j = 0; j < N; j++)
               if (win[c][j] == m_saida[c]) all_diff = 1'b0;
            if (all_diff) m_saida[c] = smp;
         end
         for (int j = D - 1; j > 0; j--) pipe[j] = pipe[j-1];
         pipe[0] = b;
      end
      m_ocup = (win[0][0] != m_saida[0]) || (win[1][0] != m_saida[1]);
   endtask

   task automatic check(input string name, input logic [1:0] act,
                        input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] b);
      rst   = r;
      bruto = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      check("model_saida", saida, m_saida);
      check("model_ocupado", {1'b0, ocupado}, {1'b0, m_ocup});
   endtask

   task automatic settle(input logic [1:0] b);
      for (int k = 0; k < LAT + 3; k++) step(1'b0, b);
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] b,
                               input logic [1:0] es, input logic eo);
      vec_t v;
      v.r = r; v.b = b; v.exp_s = es; v.exp_o = eo;
      return v;
   endfunction

   initial begin
      int  k;
      int  hi;
      bit  seen;
      bit  bad;

      for (int j = 0; j < D; j++) pipe[j] = 2'b00;

      // Reset with 11 held, release, then a clean 00->01 press.
      tbl.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0));
      tbl.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0));
      for (int i = 0; i < LAT + 3; i++)
         tbl.push_back(mk(1'b0, 2'b11, (i >= LAT) ? 2'b11 : 2'b00,
                          (i >= D) && (i < LAT)));
      tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0));
      for (int i = 0; i < LAT + 3; i++)
         tbl.push_back(mk(1'b0, 2'b01, (i >= LAT) ? 2'b01 : 2'b00,
                          (i >= D) && (i < LAT)));

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].b);
         check("tbl_saida", saida, tbl[i].exp_s);
         check("tbl_ocupado", {1'b0, ocupado}, {1'b0, tbl[i].exp_o});
      end

      // Glitch of N-1 samples is rejected.
      settle(2'b00);
      seen = 1'b0;
      bad  = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         step(1'b0, 2'b10);
         if (saida != 2'b00) bad = 1'b1;
         if (ocupado) seen = 1'b1;
      end
      for (int i = 0; i < LAT + 4; i++) begin
         step(1'b0, 2'b00);
         if (saida != 2'b00) bad = 1'b1;
         if (ocupado) seen = 1'b1;
      end
      check("glitch_reject", {1'b0, bad}, 2'b00);
      check("glitch_ocupado_pulse", {1'b0, seen}, 2'b01);
      check("glitch_ocupado_end", {1'b0, ocupado}, 2'b00);

      // Pulse of exactly N samples passes with width N.
      hi = 0;
      for (int i = 0; i < N; i++) begin
         step(1'b0, 2'b10);
         if (saida[1]) hi++;
      end
      for (int i = 0; i < LAT + N + 4; i++) begin
         step(1'b0, 2'b00);
         if (saida[1]) hi++;
      end
      check("pulse_width", 2'(hi == N), 2'b01);
      if (hi != N) $display("FAIL pulse_width_count: got %0d expected %0d", hi, N);

      // Bounce 1,0,1,0,1 then hold 1.
      bad = 1'b0;
      step(1'b0, 2'b01);
      step(1'b0, 2'b00);
      step(1'b0, 2'b01);
      step(1'b0, 2'b00);
      k = -1;
      for (int i = 0; i < LAT + 4; i++) begin
         step(1'b0, 2'b01);
         if (saida[0] && k < 0) k = i;
      end
      check("bounce_latency", 2'(k == LAT), 2'b01);
      if (k != LAT) $display("FAIL bounce_edge: got %0d expected %0d", k, LAT);

      // Simultaneous change never shows a split value.
      settle(2'b00);
      bad = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         step(1'b0, 2'b11);
         if (saida == 2'b01 || saida == 2'b10) bad = 1'b1;
      end
      check("simul_no_split", {1'b0, bad}, 2'b00);
      check("simul_final", saida, 2'b11);

      // Reset at E3 mid-count, then full requalification.
      step(1'b1, 2'b00);
      for (int i = 0; i < 3; i++) step(1'b0, 2'b01);
      step(1'b1, 2'b01);
      check("midrst_saida", saida, 2'b00);
      check("midrst_ocupado", {1'b0, ocupado}, 2'b00);
      k = -1;
      for (int i = 1; i <= LAT + 4; i++) begin
         step(1'b0, 2'b01);
         if (saida == 2'b01 && k < 0) k = i;
      end
      check("midrst_requal", 2'(k == N + D), 2'b01);
      if (k != N + D) $display("FAIL midrst_edges: got %0d expected %0d", k, N + D);

      // Randomised phase with sticky inputs and rare resets.
      for (int i = 0; i < 1500; i++) begin
         logic [1:0] b;
         b = bruto;
         if ($urandom_range(0, 3) == 0) b[0] = ~b[0];
         if ($urandom_range(0, 3) == 0) b[1] = ~b[1];
         if ($urandom_range(0, 7) == 0) b = {$urandom_range(0, 1) == 1, 1'b1};
         step($urandom_range(0, 99) == 0, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/debouncer_2ch.md
# debouncer_2ch

Two-channel input conditioner that sits directly upstream of the 2-bit edge detector. Each channel of a raw, asynchronous, bouncing input pair (push-buttons) is synchronised into the clock domain and debounced. The block then drives a clean 2-bit level bus that feeds the detector's `entrada` input. Both channels share one timing rule, so two inputs that change together reach the detector on the same clock edge.

## Interface
- `N_ESTAVEL`, 4: consecutive synchronised samples that must differ from the current output before the output changes; legal range 1 to 2^CNT_W.
- `CNT_W`, 3: width of each per-channel stability counter; must satisfy N_ESTAVEL-1 ≤ 2^CNT_W-1.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `bruto`  input  2  raw asynchronous inputs, one bit per channel.
- `saida`  output  2  debounced, synchronised levels; connects to the edge detector's `entrada`.
- `ocupado`  output  1  high while any channel counter is nonzero.

## Operation
- Per channel i, the following registers are used:
  - Synchroniser chain: `s1[i]` then `s2[i]`. The synchronised sample `s[i]` is `s2[i]`.
  - Counter `cnt[i]`, CNT_W bits.
  - Output register `saida[i]`.
- Reset, when `rst` is high at an edge, has priority over everything else:
  - All sync flops, counters and `saida` are cleared to 0.
  - Consequently `ocupado` = 0 and `saida` = 00.
- Per-channel update, each edge with `rst` low:
  - If `s[i]` == `saida[i]`, then `cnt[i]` ← 0.
  - Else if `cnt[i]` == N_ESTAVEL-1, then `saida[i]` ← `s[i]` and `cnt[i]` ← 0.
  - Else `cnt[i]` ← `cnt[i]`+1.
- Any disagreement shorter than N_ESTAVEL samples is discarded. A single agreeing sample restarts the count from 0.
- Channels are fully independent; there is no arbitration between them.
- `ocupado` = (`cnt[0]` != 0) | (`cnt[1]` != 0). It is combinational from registers.
- The counter never exceeds N_ESTAVEL-1, so it never wraps.
- N_ESTAVEL = 1 accepts any change on the first differing sample.
- Rising and falling changes are debounced symmetrically.

## Timing
- Edge E0 is the first edge that samples the new `bruto` value into `s1`.
- `saida` updates at edge E0+N_ESTAVEL+1, i.e. N_ESTAVEL+2 edges counting E0. With defaults, that is E5.
- Adding `DEBOUNCE_SYNC3_EN` (see Configuration) adds one edge of latency.
- Glitch acceptance, for a raw pulse captured on W consecutive edges:
  - The pulse is rejected iff W < N_ESTAVEL.
  - The pulse is propagated iff W ≥ N_ESTAVEL, with a width on `saida` equal to the W captured samples.
- Simultaneous change: if both bits of `bruto` change before the same edge, both bits of `saida` change at the same edge.
- Reset mid-count:
  - Counting is abandoned and `saida` reads 00 at the edge after `rst` is sampled.
  - After `rst` falls, a held input re-qualifies with full latency. The sync chain refills from 0.
- `ocupado` rises one edge after `s[i]` first differs from `saida[i]` (E2 for defaults). It falls at the edge where `saida` updates or the count is abandoned.

## Configuration
- Macro: `DEBOUNCE_SYNC3_EN`.
- Defined: the synchroniser is three flops deep (`s1`→`s2`→`s3`), with `s[i]` = `s3[i]`. Latency is N_ESTAVEL+3 edges; all other rules are unchanged. Use for metastability margin at high clock rates.
- Undefined: the two-flop chain described above is used.

## Test plan
- Reset: `bruto`=11 held, `rst`=1 for 2 edges → `saida`=00 and `ocupado`=0 throughout. Then release `rst` → `saida`=11 exactly 6 edges after the first edge with `rst` low.
- Clean press: defaults, `bruto` 00→01 held → `saida`=01 at E5 (6th edge) and not before. `ocupado`=1 from E2 through E4, 0 from E5.
- Glitch reject: `bruto[1]` high for 3 sampled edges, then low → `saida` stays 00. `ocupado` pulses and returns to 0. Repeat with 4 edges high → `saida[1]` high for exactly 4 cycles.
- Bounce: `bruto[0]` = 1,0,1,0,1 on successive edges, then held 1 → `saida[0]` rises 6 edges after the final 0→1 sample. No earlier transition.
- Simultaneous: `bruto` 00→11 before one edge → `saida` goes 00→11 in a single edge. It is never 01 or 10.
- Reset mid-count: `bruto`=01 held, `rst`=1 at E3 → `saida`=00 and `cnt`=0. With `rst` low afterwards, `saida`=01 six edges later. Rerun with `DEBOUNCE_SYNC3_EN` → 7 edges.
